// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
// Optional UART memory-mapped I/O is enabled with the UART_MMIO_EN macro.
package data_mem_ctrl_pkg;

  localparam int DATA_W      = 16;
  localparam int SRAM_ADDR_W = 18;

  localparam logic [DATA_W-1:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [DATA_W-1:0] UART_STAT_ADDR = 16'hBF01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DONE  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic doe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, doe: 1'b0};

  function automatic logic is_uart_addr(input logic [DATA_W-1:0] a);
    return (a == UART_DATA_ADDR) || (a == UART_STAT_ADDR);
  endfunction

  // SRAM strobes for a given state; a UART-targeted access keeps the SRAM
  // deselected but still drives the shared data bus during writes.
  function automatic sram_ctl_t sram_ctl(input state_t st, input logic uart_hit);
    sram_ctl_t c;
    c = SRAM_CTL_IDLE;
    case (st)
      RD_WAIT, RD_DONE: begin
        c.en_n = uart_hit;
        c.oe_n = uart_hit;
      end
      WR_SETUP, WR_DONE: begin
        c.en_n = uart_hit;
        c.doe  = 1'b1;
      end
      WR_PULSE: begin
        c.en_n = uart_hit;
        c.we_n = uart_hit;
        c.doe  = 1'b1;
      end
      default: c = SRAM_CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side MEM-stage request bus between the pipeline and the data memory controller.
interface data_mem_ctrl_if;
  import data_mem_ctrl_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              stall;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, stall
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, stall
  );

endinterface

// File: rtl/data_mem_ctrl_uart_mmio.sv
// UART address decode, status word and registered active-low UART strobes.
// Instantiated by data_mem_ctrl only when UART_MMIO_EN is defined.
module uart_mmio
  import data_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  state_t            state_d,
  input  logic [DATA_W-1:0] addr_d,
  input  logic [DATA_W-1:0] addr_q,
  input  logic              uart_data_ready,
  input  logic              uart_tbre,
  input  logic              uart_tsre,
  output logic              hit_d,
  output logic              stat_sel_q,
  output logic [DATA_W-1:0] stat_word,
  output logic              uart_rdn,
  output logic              uart_wrn
);

  logic data_sel_d;
  logic uart_rdn_q, uart_rdn_d;
  logic uart_wrn_q, uart_wrn_d;

  // Kept as separate continuous assigns so the next-address decode never
  // forms a block-level loop with the controller's next-state logic.
  assign hit_d      = is_uart_addr(addr_d);
  assign data_sel_d = (addr_d == UART_DATA_ADDR);
  assign stat_sel_q = (addr_q == UART_STAT_ADDR);
  assign stat_word  = {{(DATA_W-2){1'b0}}, uart_data_ready, uart_tbre & uart_tsre};

  assign uart_rdn_d = ~(data_sel_d && ((state_d == RD_WAIT) || (state_d == RD_DONE)));
  assign uart_wrn_d = ~(data_sel_d && (state_d == WR_PULSE));

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_rdn_q <= 1'b1;
      uart_wrn_q <= 1'b1;
    end else begin
      uart_rdn_q <= uart_rdn_d;
      uart_wrn_q <= uart_wrn_d;
    end
  end

  assign uart_rdn = uart_rdn_q;
  assign uart_wrn = uart_wrn_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: sequences asynchronous SRAM reads (3 cycles)
// and writes (4 cycles), stalling the pipeline. UART MMIO under UART_MMIO_EN.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  data_mem_ctrl_if.slave         cpu,
  output logic [SRAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]      ram_dout,
  input  logic [DATA_W-1:0]      ram_din,
  output logic                   ram_doe,
  output logic                   ram_en_n,
  output logic                   ram_oe_n,
  output logic                   ram_we_n
`ifdef UART_MMIO_EN
  ,
  output logic                   uart_rdn,
  output logic                   uart_wrn,
  input  logic                   uart_data_ready,
  input  logic                   uart_tbre,
  input  logic                   uart_tsre
`endif
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  sram_ctl_t         ctl_q, ctl_d;

  logic              req;
  logic              uart_hit_d;
  logic              rd_from_stat;
  logic [DATA_W-1:0] stat_word;

  assign req = cpu.mem_read | cpu.mem_write;

  // Next state and request latching; a write wins when both requests are high.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = cpu.address;
          wdata_d = cpu.write_data;
          state_d = cpu.mem_write ? WR_SETUP : RD_WAIT;
        end
      end
      RD_WAIT:  state_d = RD_DONE;
      RD_DONE:  state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = WR_DONE;
      WR_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == RD_DONE) begin
      rdata_d = rd_from_stat ? stat_word : ram_din;
    end
    if (rst) begin
      rdata_d = '0;
    end
  end

  // Strobes are registered from the next state so they leave the flops glitch-free.
  always_comb begin
    ctl_d = sram_ctl(state_d, uart_hit_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ctl_q   <= SRAM_CTL_IDLE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef UART_MMIO_EN
  uart_mmio u_uart_mmio (
    .clk             (clk),
    .rst             (rst),
    .state_d         (state_d),
    .addr_d          (addr_d),
    .addr_q          (addr_q),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre),
    .hit_d           (uart_hit_d),
    .stat_sel_q      (rd_from_stat),
    .stat_word       (stat_word),
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn)
  );
`else
  assign uart_hit_d   = 1'b0;
  assign rd_from_stat = 1'b0;
  assign stat_word    = '0;
`endif

  // Stall is combinational so the pipeline freezes in the accept cycle itself.
  always_comb begin
    cpu.stall = 1'b0;
    if (!rst) begin
      cpu.stall = ((state_q == IDLE) && req) ||
                  (state_q == RD_WAIT) ||
                  (state_q == WR_SETUP) ||
                  (state_q == WR_PULSE);
    end
  end

  assign cpu.read_data = rdata_q;
  assign ram_addr      = {{(SRAM_ADDR_W-DATA_W){1'b0}}, addr_q};
  assign ram_dout      = wdata_q;
  assign ram_en_n      = ctl_q.en_n;
  assign ram_oe_n      = ctl_q.oe_n;
  assign ram_we_n      = ctl_q.we_n;
  assign ram_doe       = ctl_q.doe;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver pushes expected SRAM writes and
// read results, a negedge monitor pops and compares them as the DUT produces them.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] ram_din;
  logic        ram_doe, ram_en_n, ram_oe_n, ram_we_n;
`ifdef UART_MMIO_EN
  logic        uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b1;
  logic        uart_tbre       = 1'b1;
  logic        uart_tsre       = 1'b1;
`endif

  data_mem_ctrl_if bus ();

  data_mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (bus),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din),
    .ram_doe  (ram_doe),
    .ram_en_n (ram_en_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n)
`ifdef UART_MMIO_EN
    ,
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycle    = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          en_cycles = 0;
  int          wrn_cycles = 0;
  int          oe_fall_q[$];
  logic        prev_oe_n = 1'b1;
  logic [15:0] sram_mem [0:65535];

  assign ram_din = (!ram_en_n && !ram_oe_n) ? sram_mem[ram_addr[15:0]] : 16'h0BAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit w, input logic [17:0] a, input logic [15:0] d);
    exp_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    return e;
  endfunction

  always @(posedge clk) cycle++;

  // Monitor: SRAM model plus scoreboard pop on every write pulse and read completion.
  always @(negedge clk) begin
    exp_t e;
    if (!ram_en_n) en_cycles++;
`ifdef UART_MMIO_EN
    if (!uart_wrn) wrn_cycles++;
`endif
    if (!ram_en_n && !ram_we_n) begin
      sram_mem[ram_addr[15:0]] = ram_dout;
      wr_cnt++;
      $display("txn sram_write addr=%h data=%h", ram_addr, ram_dout);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_write_kind", {31'd0, e.is_wr}, 32'd1);
        check("sb_write_addr", {14'd0, ram_addr}, {14'd0, e.addr});
        check("sb_write_data", {16'd0, ram_dout}, {16'd0, e.data});
      end
    end
    if (prev_oe_n && !ram_oe_n) begin
      rd_cnt++;
      oe_fall_q.push_back(cycle);
    end
    if (!prev_oe_n && ram_oe_n && !rst) begin
      $display("txn sram_read addr=%h data=%h", ram_addr, bus.read_data);
      if (sb_q.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_read_kind", {31'd0, e.is_wr}, 32'd0);
        check("sb_read_data", {16'd0, bus.read_data}, {16'd0, e.data});
      end
    end
    prev_oe_n = ram_oe_n;
  end

  // Present one request and hold it until the pipeline would advance past it.
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, output int n_stall);
    int k;
    n_stall = 0;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = a;
    bus.write_data = d;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.stall) n_stall++;
      else break;
    end
    if (k == 20) check("req_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rd_before, wr_before, en_before, wrn_before;
    int k;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = 16'h0000;
    bus.write_data = 16'h0000;

    // Reset values, with a request present to show stall is held low
    bus.mem_read = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_read_data", {16'd0, bus.read_data}, 32'h0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_doe", {31'd0, ram_doe}, 32'd0);
    check("rst_strobes", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'h7);
    bus.mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_stall", {31'd0, bus.stall}, 32'd0);
    check("idle_strobes_doe", {28'd0, ram_en_n, ram_oe_n, ram_we_n, ram_doe}, 32'hE);
    @(posedge clk);
    #1;

    // Write A5A5 to 4000, then read it back
    sb_q.push_back(mk(1'b1, 18'h04000, 16'hA5A5));
    do_req(1'b0, 1'b1, 16'h4000, 16'hA5A5, n);
    check("wr_stall_cycles", n, 3);
    check("wr_sram_content", {16'd0, sram_mem[16'h4000]}, 32'hA5A5);
    check("wr_keeps_read_data", {16'd0, bus.read_data}, 32'h0);
    sb_q.push_back(mk(1'b0, 18'h04000, 16'hA5A5));
    do_req(1'b1, 1'b0, 16'h4000, 16'h0000, n);
    check("rd_stall_cycles", n, 2);
    check("rd_read_data", {16'd0, bus.read_data}, 32'hA5A5);

    // Read and write together: only the write happens
    rd_before = rd_cnt;
    sb_q.push_back(mk(1'b1, 18'h00010, 16'h1234));
    do_req(1'b1, 1'b1, 16'h0010, 16'h1234, n);
    check("both_stall_cycles", n, 3);
    check("both_no_oe", rd_cnt, rd_before);
    check("both_sram_content", {16'd0, sram_mem[16'h0010]}, 32'h1234);
    check("both_read_data", {16'd0, bus.read_data}, 32'hA5A5);

    // Consecutive reads held across stall: two accesses spaced by one idle cycle
    sram_mem[16'h0001] = 16'h1111;
    sram_mem[16'h0002] = 16'h2222;
    rd_before = rd_cnt;
    oe_fall_q.delete();
    sb_q.push_back(mk(1'b0, 18'h00001, 16'h1111));
    sb_q.push_back(mk(1'b0, 18'h00002, 16'h2222));
    do_req(1'b1, 1'b0, 16'h0001, 16'h0000, n);
    check("rd1_stall_cycles", n, 2);
    do_req(1'b1, 1'b0, 16'h0002, 16'h0000, n);
    check("rd2_stall_cycles", n, 2);
    @(negedge clk);
    check("b2b_access_count", rd_cnt - rd_before, 2);
    if (oe_fall_q.size() == 2)
      check("b2b_spacing", oe_fall_q[1] - oe_fall_q[0], 3);
    else
      check("b2b_oe_falls", oe_fall_q.size(), 2);
    check("b2b_read_data", {16'd0, bus.read_data}, 32'h2222);
    @(posedge clk);
    #1;

`ifndef UART_MMIO_EN
    // UART addresses are ordinary SRAM in the default build
    sb_q.push_back(mk(1'b1, 18'h0BF00, 16'h00FF));
    do_req(1'b0, 1'b1, 16'hBF00, 16'h00FF, n);
    check("bf00_stall_cycles", n, 3);
    check("bf00_sram_content", {16'd0, sram_mem[16'hBF00]}, 32'h00FF);
`endif

    // Reset during the write pulse aborts the access
    sb_q.push_back(mk(1'b1, 18'h00020, 16'h5555));
    bus.mem_write  = 1'b1;
    bus.address    = 16'h0020;
    bus.write_data = 16'h5555;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ram_we_n) break;
    end
    if (k == 20) check("pulse_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
    check("abort_we_n", {31'd0, ram_we_n}, 32'd1);
    check("abort_stall", {31'd0, bus.stall}, 32'd0);
    check("abort_read_data", {16'd0, bus.read_data}, 32'h0);
    check("abort_en_n", {31'd0, ram_en_n}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Controller is usable again after the aborted access
    sb_q.push_back(mk(1'b0, 18'h04000, 16'hA5A5));
    do_req(1'b1, 1'b0, 16'h4000, 16'h0000, n);
    check("post_abort_stall_cycles", n, 2);
    check("post_abort_read_data", {16'd0, bus.read_data}, 32'hA5A5);

`ifdef UART_MMIO_EN
    // UART status read: no SRAM strobe, status word in read_data
    en_before = en_cycles;
    do_req(1'b1, 1'b0, 16'hBF01, 16'h0000, n);
    check("uart_stat_stall_cycles", n, 2);
    check("uart_stat_read_data", {16'd0, bus.read_data}, 32'h0003);
    check("uart_stat_no_sram", en_cycles, en_before);
    // UART data write: one uart_wrn pulse, SRAM untouched
    wrn_before = wrn_cycles;
    wr_before  = wr_cnt;
    do_req(1'b0, 1'b1, 16'hBF00, 16'h0042, n);
    check("uart_wr_stall_cycles", n, 3);
    check("uart_wrn_pulses", wrn_cycles - wrn_before, 1);
    check("uart_wr_no_sram", wr_cnt, wr_before);
    check("uart_wr_no_en", en_cycles, en_before);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have the following ports, one per line as name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 mem_read  in  1  MEM-stage load request, from the EXE/MEM register.
REQ-005 mem_write  in  1  MEM-stage store request.
REQ-006 address  in  16  word address, the ALU result.
REQ-007 write_data  in  16  store data.
REQ-008 read_data  out  16  load result, to the MEM/WB register.
REQ-009 stall  out  1  freezes PC, IF/ID, ID/EXE and EXE/MEM while high.
REQ-010 ram_addr  out  18  SRAM address, {2'b00, address}.
REQ-011 ram_dout  out  16  SRAM write data.
REQ-012 ram_din  in  16  SRAM read data.
REQ-013 ram_doe  out  1  SRAM data-bus output enable; a top-level tristate is driven from it.
REQ-014 ram_en_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
REQ-015 uart_rdn, uart_wrn  out  1 each  UART strobes, active-low; present only with UART_MMIO_EN.
REQ-016 uart_data_ready, uart_tbre, uart_tsre  in  1 each  UART status inputs; present only with UART_MMIO_EN.

Function
REQ-017 FSM states SHALL be IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE.
REQ-018 In IDLE, a request (mem_read or mem_write high) SHALL be accepted at the clock edge, latching address and write_data.
- stall is combinational and goes high in the accept cycle.
REQ-019 If mem_read and mem_write are both high, the write SHALL be serviced and the read ignored.
REQ-020 Read timing SHALL be as follows.
- Accept cycle goes to RD_WAIT with ram_en_n=0 and ram_oe_n=0.
- RD_DONE samples ram_din into read_data at its closing edge.
- stall SHALL be high in the accept and RD_WAIT cycles and low in RD_DONE; total latency is 3 cycles.
REQ-021 Write timing SHALL be as follows.
- WR_SETUP: ram_en_n=0, ram_doe=1, ram_we_n=1.
- WR_PULSE: ram_we_n=0.
- WR_DONE: ram_we_n=1, ram_doe still 1.
- stall SHALL be low in WR_DONE; total latency is 4 cycles.
REQ-022 RD_DONE and WR_DONE SHALL return to IDLE.
- A new request present in the RD_DONE/WR_DONE cycle SHALL be accepted only in the following IDLE cycle, so there is never back-to-back acceptance.
REQ-023 ram_addr and ram_dout SHALL come from the latched values and be stable for the whole access.
REQ-024 read_data SHALL hold its last loaded value until the next completed read; writes SHALL leave it unchanged.
REQ-025 With no request, the FSM SHALL stay in IDLE with all strobes high, ram_doe=0 and stall=0.

Reset
REQ-026 While rst is high, the next state SHALL be IDLE.
REQ-027 Reset SHALL force read_data=16'h0000, stall=0, ram_doe=0, all *_n strobes=1 and latched address/data=0.
REQ-028 Reset asserted mid-access SHALL abort the access at that edge.
- An in-progress write pulse is cut; memory content at that address is undefined.

Configuration
REQ-029 With macro UART_MMIO_EN defined, addresses 16'hBF00 (data) and 16'hBF01 (status) SHALL be decoded to the UART and never reach SRAM.
- Status read SHALL return {14'b0, uart_data_ready, uart_tbre & uart_tsre}.
- Status read SHALL complete in the RD_WAIT timing with no strobe.
- Data read SHALL drive uart_rdn=0 for the RD_WAIT and RD_DONE cycles and sample ram_din in RD_DONE.
- Data write SHALL use the write timing with uart_wrn=0 in WR_PULSE, in place of ram_we_n.
- Status writes are ignored but still take the 4-cycle write timing.
REQ-030 Without UART_MMIO_EN, the UART ports SHALL be absent and 16'hBF00/16'hBF01 SHALL be ordinary SRAM addresses.

Structure
REQ-031 A shared package SHALL hold the state enum, UART_DATA_ADDR=16'hBF00, UART_STAT_ADDR=16'hBF01 and the SRAM address width (18).
REQ-032 The UART decode and strobe logic SHALL be a sub-module uart_mmio, instantiated only under UART_MMIO_EN; SRAM sequencing stays in data_mem_ctrl.

Verification
REQ-033 The bench SHALL cover the following directed scenarios.
- Write 16'hA5A5 to 16'h4000, then read 16'h4000 -> SRAM model holds A5A5; stall high 3 cycles then 2 cycles; read_data=16'hA5A5.
- mem_read and mem_write both high, address 16'h0010, data 16'h1234 -> write only; ram_oe_n never low; read_data unchanged.
- rst asserted in the WR_PULSE cycle -> next cycle IDLE, ram_we_n=1, stall=0, read_data=0.
- Consecutive reads of 16'h0001 and 16'h0002 held over stall -> exactly 2 accesses, second accepted one cycle after the first RD_DONE.
- UART_MMIO_EN defined, uart_tbre=uart_tsre=1, data_ready=1, read 16'hBF01 -> read_data=16'h0003; no SRAM strobe.
- UART_MMIO_EN undefined, write 16'h00FF to 16'hBF00 -> SRAM write at 18'h0BF00; no UART port exists.
